// File: rtl/hack_mmio_peripherals_if.sv
// Hack CPU data-bus view of the MMIO peripheral window.
// master: CPU side, which drives the step strobe, address, write enable and write data.
// slave : peripheral side, which returns read data and the window select.
interface hack_mmio_peripherals_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15
);
  logic                     hack_step;
  logic [ADDRESS_WIDTH-1:0] hack_addressM;
  logic                     hack_writeM;
  logic [WORD_WIDTH-1:0]    hack_outM;
  logic [WORD_WIDTH-1:0]    hack_inM;
  logic                     sel;

  modport master (
    output hack_step, hack_addressM, hack_writeM, hack_outM,
    input  hack_inM, sel
  );
  modport slave (
    input  hack_step, hack_addressM, hack_writeM, hack_outM,
    output hack_inM, sel
  );
endinterface

// File: rtl/hack_mmio_peripherals.sv
// Hack SoC memory-mapped peripheral block.
//   BASE     : keyboard FIFO head (a read with a step pops it)
//   BASE+1   : status {overflow, 0.., count} (a write clears overflow)
//   BASE+2+k : GPIO word register k
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   hack_external_reset - external CPU reset request
//   subsystem_ready     - memories initialised; the CPU is held in reset while low
//   bus (slave)         - Hack data bus: step, addressM, writeM, outM, inM, sel
//   keycode             - live key code, 0 = no key
//   hack_reset          - CPU reset, held RESET_WAIT_STEPS steps after the sources clear
//   gpio                - flattened GPIO registers, channel k at [k*WORD_WIDTH +: WORD_WIDTH]
module hack_mmio_peripherals #(
  parameter int WORD_WIDTH       = 16,
  parameter int ADDRESS_WIDTH    = 15,
  parameter int BASE_ADDRESS     = 24576,
  parameter int GPIO_CHANNELS    = 2,
  parameter int KEY_FIFO_DEPTH   = 4,
  parameter int RESET_WAIT_STEPS = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                hack_external_reset,
  input  logic                                subsystem_ready,
  hack_mmio_peripherals_if.slave              bus,
  input  logic [7:0]                          keycode,
  output logic                                hack_reset,
  output logic [GPIO_CHANNELS*WORD_WIDTH-1:0] gpio
);
  localparam int PTR_W   = $clog2(KEY_FIFO_DEPTH);
  localparam int COUNT_W = $clog2(KEY_FIFO_DEPTH + 1);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] NREGS  = ADDRESS_WIDTH'(GPIO_CHANNELS + 2);

  // Reset sequencer: reload while any source is active, then count steps down.
  logic       src_rst;
  logic [3:0] wait_cnt;

  assign src_rst    = reset | hack_external_reset | ~subsystem_ready;
  assign hack_reset = src_rst | (wait_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (src_rst)                           wait_cnt <= 4'(RESET_WAIT_STEPS);
    else if (bus.hack_step && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Decode. The offset wraps for addresses below BASE. The explicit >= check
  // keeps those addresses out of the window.
  logic [ADDRESS_WIDTH-1:0] off;
  logic acc_ok, wr_en, rd_en, is_key, is_stat;

  assign off     = bus.hack_addressM - BASE_A;
  assign bus.sel = (bus.hack_addressM >= BASE_A) && (off < NREGS);
  assign acc_ok  = bus.hack_step & ~hack_reset & bus.sel;
  assign wr_en   = acc_ok & bus.hack_writeM;
  assign rd_en   = acc_ok & ~bus.hack_writeM;
  assign is_key  = (off == '0);
  assign is_stat = (off == ADDRESS_WIDTH'(1));

  // GPIO registers
  logic [GPIO_CHANNELS-1:0][WORD_WIDTH-1:0] gpio_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < GPIO_CHANNELS; k++) begin
      if (hack_reset)                                gpio_q[k] <= '0;
      else if (wr_en && off == ADDRESS_WIDTH'(k + 2)) gpio_q[k] <= bus.hack_outM;
    end
  end
  assign gpio = gpio_q;

  // Keyboard capture and FIFO. A push is edge-like on the key code and does
  // not wait for a step.
  logic [7:0]         prev_key;
  logic [7:0]         fifo_mem [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               key_push, pop, full, do_push, ovf_set, ovf_clr;

  assign key_push = (keycode != 8'd0) && (keycode != prev_key);
  assign full     = (count == COUNT_W'(KEY_FIFO_DEPTH));
  assign pop      = rd_en && is_key && (count != '0);
  // When the FIFO is full, a simultaneous pop frees a slot for the push.
  assign do_push  = key_push && (!full || pop);
  assign ovf_set  = key_push && full && !pop;
  assign ovf_clr  = wr_en && is_stat;

  always_ff @(posedge clk) begin
    if (reset) prev_key <= 8'd0;
    else       prev_key <= keycode;
  end

  always_ff @(posedge clk) begin
    if (do_push && !hack_reset) fifo_mem[wr_ptr] <= keycode;
  end

  always_ff @(posedge clk) begin
    if (hack_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + COUNT_W'(do_push) - COUNT_W'(pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Read mux (combinational, zero latency)
  logic [WORD_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (bus.sel) begin
      if (is_key) begin
        if (count != '0) rdata[7:0] = fifo_mem[rd_ptr];
      end else if (is_stat) begin
        rdata[WORD_WIDTH-1] = overflow;
        rdata[COUNT_W-1:0]  = count;
      end else begin
        for (int k = 0; k < GPIO_CHANNELS; k++)
          if (off == ADDRESS_WIDTH'(k + 2)) rdata = gpio_q[k];
      end
    end
  end
  assign bus.hack_inM = rdata;
endmodule

// File: tb/tb_hack_mmio_peripherals.sv
module tb_hack_mmio_peripherals;
  localparam int WW = 16, AW = 15, BASE = 24576, NG = 2, DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset, ext_rst, ready, hack_reset;
  logic [7:0]       keycode;
  logic [NG*WW-1:0] gpio;

  hack_mmio_peripherals_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  hack_mmio_peripherals #(
    .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .BASE_ADDRESS(BASE),
    .GPIO_CHANNELS(NG), .KEY_FIFO_DEPTH(DEPTH), .RESET_WAIT_STEPS(2)
  ) dut (
    .clk(clk), .reset(reset), .hack_external_reset(ext_rst),
    .subsystem_ready(ready), .bus(bus), .keycode(keycode),
    .hack_reset(hack_reset), .gpio(gpio)
  );

  always #5 clk = ~clk;

  int          vec = 0, miss = 0;
  logic [15:0] exp_q [$];     // scoreboard of expected FIFO contents
  logic [7:0]  mprev = 8'd0;  // bench view of the previous key
  logic        movf  = 1'b0;  // bench view of the overflow flag
  logic [15:0] got, exp;
  logic        s;

  task automatic tick(input logic step);
    bus.hack_step = step;
    @(posedge clk); #1;
    bus.hack_step = 1'b0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
    bus.hack_addressM = a; bus.hack_writeM = 1'b1; bus.hack_outM = d;
    tick(1'b1);
    bus.hack_writeM = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [15:0] d, output logic sl);
    bus.hack_addressM = a; bus.hack_writeM = 1'b0;
    #1;
    d = bus.hack_inM; sl = bus.sel;
  endtask

  // Drive a key code for n cycles and record the expected FIFO effect.
  task automatic key(input logic [7:0] code, input int n);
    keycode = code;
    if (code != 8'd0 && code != mprev) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({8'h00, code});
      else                      movf = 1'b1;
    end
    mprev = code;
    repeat (n) tick(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; ext_rst = 1'b0; ready = 1'b1; keycode = 8'd0;
    bus.hack_step = 1'b0; bus.hack_addressM = '0; bus.hack_writeM = 1'b0; bus.hack_outM = '0;
    repeat (3) tick(1'b0);
    vec++; if (hack_reset !== 1'b1) begin miss++; $display("FAIL reset_hold: got %b want 1", hack_reset); end
    vec++; if (gpio !== '0) begin miss++; $display("FAIL reset_gpio: got %h want 0", gpio); end
    peek(AW'(BASE + 1), got, s);
    vec++; if (got !== 16'h0000 || s !== 1'b1) begin miss++; $display("FAIL reset_status: got %h sel %b want 0000 sel 1", got, s); end
    peek(AW'(BASE), got, s);
    vec++; if (got !== 16'h0000) begin miss++; $display("FAIL reset_key: got %h want 0000", got); end
  endtask

  task automatic test_sequencer;
    reset = 1'b0;
    for (int st = 0; st < 2; st++) begin
      repeat (3) begin
        tick(1'b0);
        vec++; if (hack_reset !== 1'b1) begin miss++; $display("FAIL seq_wait%0d: got %b want 1", st, hack_reset); end
      end
      tick(1'b1);
      exp = (st == 1) ? 16'd0 : 16'd1;
      vec++; if (hack_reset !== exp[0]) begin miss++; $display("FAIL seq_step%0d: got %b want %b", st, hack_reset, exp[0]); end
    end
    ready = 1'b0; #1;
    vec++; if (hack_reset !== 1'b1) begin miss++; $display("FAIL seq_notready: got %b want 1", hack_reset); end
    tick(1'b0);
    ready = 1'b1; #1;
    vec++; if (hack_reset !== 1'b1) begin miss++; $display("FAIL seq_ready_reload: got %b want 1", hack_reset); end
    tick(1'b1);
    vec++; if (hack_reset !== 1'b1) begin miss++; $display("FAIL seq_ready_step1: got %b want 1", hack_reset); end
    tick(1'b1);
    vec++; if (hack_reset !== 1'b0) begin miss++; $display("FAIL seq_ready_step2: got %b want 0", hack_reset); end
  endtask

  task automatic test_gpio;
    bus_write(AW'(BASE + 2), 16'hBEEF);
    bus_write(AW'(BASE + 3), 16'h1234);
    vec++; if (gpio !== {16'h1234, 16'hBEEF}) begin miss++; $display("FAIL gpio_write: got %h want 1234beef", gpio); end
    peek(AW'(BASE + 2), got, s);
    vec++; if (got !== 16'hBEEF || s !== 1'b1) begin miss++; $display("FAIL gpio_read0: got %h sel %b want beef sel 1", got, s); end
    peek(AW'(BASE + 3), got, s);
    vec++; if (got !== 16'h1234) begin miss++; $display("FAIL gpio_read1: got %h want 1234", got); end
    bus.hack_addressM = AW'(BASE + 2); bus.hack_writeM = 1'b1; bus.hack_outM = 16'hAAAA;
    tick(1'b0);
    bus.hack_writeM = 1'b0;
    vec++; if (gpio !== {16'h1234, 16'hBEEF}) begin miss++; $display("FAIL gpio_nostep: got %h want 1234beef", gpio); end
    ext_rst = 1'b1;
    tick(1'b0);
    vec++; if (gpio !== '0 || hack_reset !== 1'b1) begin miss++; $display("FAIL gpio_extrst: got %h rst %b want 0 rst 1", gpio, hack_reset); end
    ext_rst = 1'b0;
    // These steps occur while the CPU is still held in reset, so both writes are dropped.
    bus_write(AW'(BASE + 2), 16'h5555);
    bus_write(AW'(BASE + 3), 16'h6666);
    vec++; if (gpio !== '0 || hack_reset !== 1'b0) begin miss++; $display("FAIL gpio_holdoff: got %h rst %b want 0 rst 0", gpio, hack_reset); end
  endtask

  task automatic test_fifo;
    key(8'h41, 10); key(8'h00, 1); key(8'h42, 1); key(8'h43, 1); key(8'h00, 1);
    peek(AW'(BASE + 1), got, s);
    exp = 16'(exp_q.size());
    vec++; if (got !== exp) begin miss++; $display("FAIL fifo_count: got %h want %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      peek(AW'(BASE), got, s);
      exp = exp_q.pop_front();
      vec++; if (got !== exp) begin miss++; $display("FAIL fifo_pop%0d: got %h want %h", i, got, exp); end
      tick(1'b1);
    end
    peek(AW'(BASE), got, s);
    vec++; if (got !== 16'h0000) begin miss++; $display("FAIL fifo_empty: got %h want 0000", got); end
    peek(AW'(BASE + 1), got, s);
    vec++; if (got !== 16'h0000) begin miss++; $display("FAIL fifo_empty_status: got %h want 0000", got); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) key(8'h11 + 8'(i), 1);
    key(8'h00, 1);
    peek(AW'(BASE + 1), got, s);
    exp = {movf, 15'(exp_q.size())};
    vec++; if (got !== exp) begin miss++; $display("FAIL ovf_status: got %h want %h", got, exp); end
    bus_write(AW'(BASE + 1), 16'hFFFF);
    movf = 1'b0;
    peek(AW'(BASE + 1), got, s);
    exp = {movf, 15'(exp_q.size())};
    vec++; if (got !== exp) begin miss++; $display("FAIL ovf_clear: got %h want %h", got, exp); end
    peek(AW'(BASE), got, s);
    vec++; if (got !== exp_q[0]) begin miss++; $display("FAIL ovf_head: got %h want %h", got, exp_q[0]); end
  endtask

  task automatic test_push_pop_full;
    // The FIFO is full at this point. Pop it and push a new key on the same edge.
    bus.hack_addressM = AW'(BASE); bus.hack_writeM = 1'b0; keycode = 8'h55; #1;
    got = bus.hack_inM;
    exp = exp_q.pop_front();
    vec++; if (got !== exp) begin miss++; $display("FAIL pp_head: got %h want %h", got, exp); end
    exp_q.push_back(16'h0055); mprev = 8'h55;
    tick(1'b1);
    key(8'h00, 1);
    peek(AW'(BASE + 1), got, s);
    exp = {movf, 15'(exp_q.size())};
    vec++; if (got !== exp) begin miss++; $display("FAIL pp_status: got %h want %h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      peek(AW'(BASE), got, s);
      exp = exp_q.pop_front();
      vec++; if (got !== exp) begin miss++; $display("FAIL pp_drain%0d: got %h want %h", i, got, exp); end
      tick(1'b1);
    end
  endtask

  task automatic test_decode;
    key(8'h66, 1); key(8'h00, 1);
    peek(AW'(BASE - 1), got, s);
    vec++; if (got !== 16'h0000 || s !== 1'b0) begin miss++; $display("FAIL dec_below: got %h sel %b want 0000 sel 0", got, s); end
    tick(1'b1);
    peek(AW'(BASE + 2 + NG), got, s);
    vec++; if (got !== 16'h0000 || s !== 1'b0) begin miss++; $display("FAIL dec_above: got %h sel %b want 0000 sel 0", got, s); end
    tick(1'b1);
    bus_write(AW'(BASE + 2 + NG), 16'hDEAD);
    bus_write(AW'(BASE), 16'h00FF);
    vec++; if (gpio !== '0) begin miss++; $display("FAIL dec_gpio: got %h want 0", gpio); end
    peek(AW'(BASE + 1 + NG), got, s);
    vec++; if (s !== 1'b1) begin miss++; $display("FAIL dec_last_sel: got %b want 1", s); end
    peek(AW'(BASE + 1), got, s);
    exp = {movf, 15'(exp_q.size())};
    vec++; if (got !== exp) begin miss++; $display("FAIL dec_status: got %h want %h", got, exp); end
    peek(AW'(BASE), got, s);
    exp = exp_q.pop_front();
    vec++; if (got !== exp) begin miss++; $display("FAIL dec_head: got %h want %h", got, exp); end
    tick(1'b1);
    peek(AW'(BASE + 1), got, s);
    vec++; if (got !== 16'h0000) begin miss++; $display("FAIL dec_final: got %h want 0000", got); end
  endtask

  initial begin
    test_reset();
    test_sequencer();
    test_gpio();
    test_fifo();
    test_overflow();
    test_push_pop_full();
    test_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
